pipe_stage_buf: RTL and testbench
=================================

Name: pipe_stage_buf

Overview:
- Parametrised elastic pipeline-stage register for the pipelined CPU datapath, replacing fixed single-entry inter-stage latches (e.g. MEM/WB).
- Carries an opaque WIDTH-bit stage bundle (control bits, result, load data, dest reg, PC+4) from producer stage to consumer stage.
- Adds a DEPTH-entry buffer with valid/ready handshake, global enable (freeze), flush, and occupancy/flush-drop reporting that the single-entry latch lacks.

Parameters:
- WIDTH, 32, bits per stage bundle (>=1).
- DEPTH, 2, buffer entries; power of 2, >=2.
- CNT_W, 8, width of saturating flushed-entry drop counter.

Ports:
- CLK  in  1  system clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- enable  in  1  1 = stage advances; 0 = freeze (no push, no pop).
- flush  in  1  discard all buffered entries this cycle.
- in_valid  in  1  producer has a bundle.
- in_ready  out  1  buffer accepts a bundle this cycle.
- in_data  in  WIDTH  producer bundle.
- out_valid  out  1  head bundle presented to consumer.
- out_ready  in  1  consumer takes head this cycle.
- out_data  out  WIDTH  head bundle.
- occupancy  out  $clog2(DEPTH+1)  entries held.
- drop_cnt  out  CNT_W  total entries discarded by flush, saturating.

Behaviour:
- Reset (async, immediate): head=tail=0, occupancy=0, drop_cnt=0, storage zeroed, out_valid=0, out_data=0, in_ready=0 while RST high.
- push = in_valid & in_ready; pop = out_valid & out_ready; both take effect on the rising edge.
- in_ready = enable & ~flush & (occupancy < DEPTH), combinational. No push-through when full: with occupancy==DEPTH, in_ready=0 even if pop is asserted.
- out_valid = enable & (occupancy != 0), combinational.
- out_data = out_valid ? storage[head] : 0. There is no bypass, so minimum latency from push to out_valid is 1 cycle.
- Push writes storage[tail] and increments tail mod DEPTH. Pop increments head mod DEPTH.
- Occupancy update:
  - +1 on push only.
  - -1 on pop only.
  - Unchanged on simultaneous push and pop.
- enable=0: no state change (pointers, occupancy, storage and drop_cnt hold). out_valid=0 and in_ready=0. Contents reappear unchanged when enable returns to 1.
- flush=1 (regardless of enable):
  - Next edge sets head=tail=0 and occupancy=0.
  - Any concurrent push is blocked (in_ready=0). Any concurrent pop still completes, so the consumer may consume the head in the flush cycle.
  - drop_cnt += (occupancy - pop), saturating at 2^CNT_W-1.
  - Storage contents are not cleared.
- Pointer wrap-around: pointers are $clog2(DEPTH) bits and wrap naturally. The full/empty distinction comes from occupancy, never from pointer equality.
- RST asserted mid-operation: all state returns to reset values immediately. Buffered entries are lost and are not counted in drop_cnt.

Decomposition:
- cpu_types_pkg holds the stage-bundle typedefs (word_t, opcode_t, regbits) that callers pack into in_data. pipe_stage_buf itself stays type-agnostic (flat WIDTH vector).
- New package constants: PIPE_BUF_DEPTH_DEFAULT=2 and the mem/wb bundle width, derived from $bits of a packed struct mem_wb_t defined in cpu_types_pkg.
- One sub-module: pipe_buf_ram, a DEPTH x WIDTH register array.
  - Single write port (we, waddr, wdata) and combinational read (raddr, rdata).
  - Async clear on RST.

Test Plan:
- Reset then single push: RST pulse, in_valid=1, in_data=0xDEADBEEF for 1 cycle, out_ready=0 -> out_valid=1 next cycle, out_data=0xDEADBEEF, occupancy=1.
- Fill to full (DEPTH=2): push 0x11, then 0x22, with out_ready=0 -> occupancy=2, in_ready=0. A third push with in_valid=1 is not accepted. Popping 2 cycles yields 0x11 then 0x22 in order, and occupancy returns to 0.
- Streaming wrap-around: push and pop every cycle for 10 cycles with values 1..10 -> occupancy constant at 1 and outputs 1..10 in order, exercising the pointer wrap.
- Freeze: occupancy=1 holding 0xA5, enable=0 for 3 cycles with in_valid=out_ready=1 -> out_valid=0, in_ready=0, occupancy stays 1. Returning enable=1 shows out_data=0xA5.
- Flush with concurrent pop: occupancy=2, flush=1, out_ready=1 -> head consumed that cycle, next cycle occupancy=0, drop_cnt=1, out_valid=0, out_data=0.
- Async reset mid-stream: assert RST between clock edges with occupancy=2 -> out_valid=0, occupancy=0 immediately, drop_cnt=0.

Source files
------------

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and pipeline-buffer constants.
// The MEM/WB bundle width is derived from the packed struct, so it follows any field change.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'h03,
    OP_OPIMM  = 7'h13,
    OP_STORE  = 7'h23,
    OP_OP     = 7'h33,
    OP_BRANCH = 7'h63,
    OP_JAL    = 7'h6F
  } opcode_t;

  typedef struct packed {
    logic   reg_write;
    logic   mem_to_reg;
    word_t  alu_result;
    word_t  load_data;
    regbits rd;
    word_t  pc_plus4;
  } mem_wb_t;

  localparam int PIPE_BUF_DEPTH_DEFAULT = 2;
  localparam int MEM_WB_W               = $bits(mem_wb_t);

endpackage

// File: rtl/pipe_buf_ram.sv
// DEPTH x WIDTH register array with one write port and a combinational read port.
// Reset clears the whole array.
module pipe_buf_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];

  always_comb begin
    mem_d = mem_q;
    if (we) mem_d[waddr] = wdata;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/pipe_stage_buf.sv
// Elastic inter-stage buffer: DEPTH-entry FIFO with valid/ready, freeze, flush,
// occupancy output and a saturating count of entries discarded by flush.
module pipe_stage_buf
  import cpu_types_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = PIPE_BUF_DEPTH_DEFAULT,
  parameter int CNT_W = 8
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       enable,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] occupancy,
  output logic [CNT_W-1:0]           drop_cnt
);

  localparam int AW    = $clog2(DEPTH);
  localparam int OCC_W = $clog2(DEPTH+1);
  localparam logic [OCC_W-1:0] FULL = OCC_W'(DEPTH);

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             push, pop;
  logic [WIDTH-1:0] rdata;

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] cnt,
                                                input logic [OCC_W-1:0] inc);
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + (CNT_W+1)'(inc);
    return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
  endfunction

  // RST gates in_ready so nothing is offered as accepted while reset is held.
  assign in_ready  = ~RST & enable & ~flush & (occ_q < FULL);
  assign out_valid = enable & (occ_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? rdata : '0;
  assign occupancy = occ_q;
  assign drop_cnt  = drop_q;

  always_comb begin
    head_d = head_q;
    tail_d = tail_q;
    occ_d  = occ_q;
    drop_d = drop_q;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
      drop_d = sat_add(drop_q, occ_q - OCC_W'(pop));
    end else if (enable) begin
      if (push) tail_d = tail_q + AW'(1);
      if (pop)  head_d = head_q + AW'(1);
      if (push && !pop)      occ_d = occ_q + OCC_W'(1);
      else if (pop && !push) occ_d = occ_q - OCC_W'(1);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      drop_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      drop_q <= drop_d;
    end
  end

  pipe_buf_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .CLK   (CLK),
    .RST   (RST),
    .we    (push),
    .waddr (tail_q),
    .wdata (in_data),
    .raddr (head_q),
    .rdata (rdata)
  );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: directed scenarios then random traffic, all checked
// against a queue-based model of the buffer's rules.
module tb_pipe_stage_buf;

  localparam int WIDTH = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int DROP_MAX = (1 << CNT_W) - 1;

  logic                       CLK = 1'b0;
  logic                       RST;
  logic                       enable, flush, in_valid, out_ready;
  logic                       in_ready, out_valid;
  logic [WIDTH-1:0]           in_data, out_data;
  logic [$clog2(DEPTH+1)-1:0] occupancy;
  logic [CNT_W-1:0]           drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [WIDTH-1:0] mq[$];
  int               mdrop = 0;

  pipe_stage_buf #(.WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .enable    (enable),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .occupancy (occupancy),
    .drop_cnt  (drop_cnt)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive at negedge, check combinational outputs, then advance the model at posedge.
  task automatic step(input logic en, input logic fl, input logic iv,
                      input logic [WIDTH-1:0] d, input logic ordy);
    logic exp_ir, exp_ov, do_push, do_pop;
    logic [WIDTH-1:0] exp_od;
    @(negedge CLK);
    enable = en; flush = fl; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    exp_ir = en && !fl && (mq.size() < DEPTH);
    exp_ov = en && (mq.size() != 0);
    exp_od = exp_ov ? mq[0] : '0;
    check("in_ready",  32'(in_ready),  32'(exp_ir));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("out_data",  out_data,       exp_od);
    check("occupancy", 32'(occupancy), mq.size());
    check("drop_cnt",  32'(drop_cnt),  mdrop);
    do_push = iv && exp_ir;
    do_pop  = exp_ov && ordy;
    @(posedge CLK);
    if (do_pop) void'(mq.pop_front());
    if (fl) begin
      mdrop = mdrop + mq.size();
      if (mdrop > DROP_MAX) mdrop = DROP_MAX;
      mq.delete();
    end else if (do_push) begin
      mq.push_back(d);
    end
  endtask

  initial begin
    RST = 1'b1; enable = 1'b1; flush = 1'b0; in_valid = 1'b1; out_ready = 1'b0; in_data = '0;
    #2;
    check("rst_in_ready",  32'(in_ready),  0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_occupancy", 32'(occupancy), 0);
    check("rst_drop_cnt",  32'(drop_cnt),  0);
    #6 RST = 1'b0;

    // Single push, visible one cycle later.
    step(1, 0, 1, 32'hDEADBEEF, 0);
    step(1, 0, 0, 32'h0, 0);
    check("single_push_data", out_data, 32'hDEADBEEF);
    step(1, 0, 0, 32'h0, 1);

    // Fill to full, refused third push, ordered drain.
    step(1, 0, 1, 32'h11, 0);
    step(1, 0, 1, 32'h22, 0);
    step(1, 0, 1, 32'h33, 1);
    step(1, 0, 0, 32'h0, 1);
    step(1, 0, 0, 32'h0, 0);

    // Streaming 1..10 with a push and pop every cycle.
    step(1, 0, 1, 32'd1, 0);
    for (int i = 2; i <= 11; i++) step(1, 0, (i <= 10), 32'(i), 1);

    // Freeze with one entry held.
    step(1, 0, 1, 32'hA5, 0);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 32'h5A, 1);
    step(1, 0, 0, 32'h0, 0);
    check("freeze_resume", out_data, 32'hA5);
    step(1, 0, 0, 32'h0, 1);

    // Flush with concurrent pop from a full buffer.
    step(1, 0, 1, 32'h77, 0);
    step(1, 0, 1, 32'h88, 0);
    step(1, 1, 1, 32'h99, 1);
    step(1, 0, 0, 32'h0, 0);
    check("flush_drop", 32'(drop_cnt), 1);

    // Async reset between edges with two entries held.
    step(1, 0, 1, 32'hC1, 0);
    step(1, 0, 1, 32'hC2, 0);
    #2 RST = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_occupancy", 32'(occupancy), 0);
    check("arst_drop_cnt",  32'(drop_cnt),  0);
    check("arst_out_data",  out_data,       0);
    mq.delete();
    mdrop = 0;
    #1 RST = 1'b0;

    // Random traffic, including enough flushes to saturate drop_cnt.
    for (int i = 0; i < 600; i++)
      step(($urandom % 8) != 0, ($urandom % 9) == 0, $urandom % 2,
           $urandom, ($urandom % 3) != 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
